dsp_mul_sequencer: RTL and testbench
====================================

// Module: dsp_mul_sequencer
// PURPOSE
//  RV32M multiply unit built on one shared 16x16 unsigned DSP multiplier.
//  Splits a 32x32 multiply into four 16x16 partial products and issues them one per cycle.
//  Accumulates a 64-bit product, applies the signed correction, then returns the low or high word.
//  Sits beside the ALU in the execute stage; the hazard unit stalls the pipe while busy is high.
// PARAMETERS
//  DSP_LATENCY  1  cycles from operands presented to product valid at the dsp_mul16_pipe output (legal 1..3)
// PORTS
//  clk           in   1   core clock; all state changes on its rising edge
//  rst           in   1   synchronous, active-high reset
//  req_valid     in   1   multiply request present
//  req_ready     out  1   unit can accept a request; high only in IDLE
//  req_op        in   2   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
//  req_a         in   32  rs1 operand
//  req_b         in   32  rs2 operand
//  flush         in   1   abort the in-flight operation (branch/exception flush)
//  busy          out  1   operation in flight (state != IDLE)
//  result_valid  out  1   one-cycle pulse; result is valid in that cycle
//  result        out  32  product word; holds its value until the next result_valid
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, busy=0, result_valid=0, result=0, accumulator=0, in-flight pipe cleared.
//  Accept: req_valid && req_ready && !flush in cycle T latches a, b and op; state goes to ISSUE.
//  FSM:
//   IDLE  -> ISSUE on accept.
//   ISSUE -> 4 cycles, k=0..3, one partial per cycle:
//            k0 aL*bL <<0, k1 aL*bH <<16, k2 aH*bL <<16, k3 aH*bH <<32.
//            After k=3, go to DRAIN.
//   DRAIN -> DSP_LATENCY cycles, then FIX.
//   FIX   -> one cycle, then IDLE.
//  In-flight tracking: a valid/shift tag pipe of depth DSP_LATENCY travels with each issued partial.
//   When a tag emerges, the product is zero-extended, shifted and added to the 64-bit accumulator, mod 2^64.
//   The accumulator clears on accept.
//  All four partials always issue, including for MUL, so latency is fixed.
//  Signed correction, applied in FIX, mod 2^64:
//   Subtract b<<32 if a is treated as signed and a[31]=1 (MULH, MULHSU).
//   Subtract a<<32 if b is treated as signed and b[31]=1 (MULH only).
//  Result select: MUL takes P[31:0]; the others take P[63:32].
//   result is registered at the end of FIX; result_valid pulses in cycle T+6+DSP_LATENCY.
//  Back-to-back: state is IDLE in the result_valid cycle, so req_ready=1 there and a new request may be accepted.
//  Flush: has priority over everything.
//   Any state -> IDLE next cycle. The tag pipe and accumulator clear; no result_valid; result is unchanged.
//   req_valid during flush is not accepted.
//   A flush in the FIX cycle suppresses that result.
//  rst mid-operation: same as flush, and also clears result to 0.
//  req_valid while busy is ignored; the requester holds it until req_ready.
//  Operands are latched, so changes on req_a/req_b after accept have no effect.
// STRUCTURE
//  Shared header mul_defs.vh holds:
//   op encodings MUL_OP_MUL/MULH/MULHSU/MULHU;
//   state encodings MS_IDLE/ISSUE/DRAIN/FIX;
//   partial-index constants.
//  Sub-module dsp_mul16_pipe, parameter LATENCY:
//   wraps SB_MAC16 in unsigned 16x16 multiply mode, 32-bit output;
//   input and output register enables are set to meet LATENCY.
//   This sequencer owns the single instance; there is no other user of the multiplier.
//  Sequencer body: FSM, 2-bit partial counter, drain counter, tag pipe, operand-half mux, accumulator, correction.
// TESTING
//  MUL 3 x 5, DSP_LATENCY=1 -> result=0x0000000F; result_valid exactly 7 cycles after accept; busy high for 6 cycles.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  MUL of the same operands -> 0x00000001.
//  MULH 0x80000000 x 0x80000000 -> 0x40000000.
//  MULH 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
//  MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
//  MULHU 0xFFFFFFFF x 0x00000002 -> 0x00000001.
//  Flush on the 2nd ISSUE cycle:
//   -> IDLE next cycle; no result_valid; result keeps its old value.
//   -> a new MUL 7 x 6 issued right after returns 0x0000002A with normal latency.
//  Back-to-back: req_valid held with MUL 2x2 then MUL 4x4:
//   -> second request accepted in the cycle of the first result_valid;
//   -> results 4 then 16; req_ready low throughout busy.
//  rst asserted in DRAIN -> all outputs at reset values next cycle; no stale accumulation reaches a later result.
//  Random signed/unsigned operands across all ops at DSP_LATENCY=1, 2 and 3 -> match a 64-bit reference model.

Source files
------------

// File: rtl/dsp_mul_sequencer_pkg.sv
// Shared definitions for the RV32M multiply sequencer: op and state encodings,
// partial-product indices and small decode helpers.
package dsp_mul_sequencer_pkg;

   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'b00,
      MUL_OP_MULH   = 2'b01,
      MUL_OP_MULHSU = 2'b10,
      MUL_OP_MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      MS_IDLE,
      MS_ISSUE,
      MS_DRAIN,
      MS_FIX
   } mul_state_e;

   // Partial index bit 1 selects the high half of a, bit 0 the high half of b.
   typedef logic [1:0] part_idx_t;
   localparam part_idx_t PART_LL = 2'd0;
   localparam part_idx_t PART_LH = 2'd1;
   localparam part_idx_t PART_HL = 2'd2;
   localparam part_idx_t PART_HH = 2'd3;

   function automatic logic [5:0] partial_shift(part_idx_t k);
      case (k)
         PART_LL: return 6'd0;
         PART_HH: return 6'd32;
         default: return 6'd16;
      endcase
   endfunction

   function automatic logic a_is_signed(mul_op_e op);
      return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
   endfunction

   function automatic logic b_is_signed(mul_op_e op);
      return op == MUL_OP_MULH;
   endfunction

endpackage

// File: rtl/dsp_mul_sequencer_if.sv
// Request/result bus between the execute stage and the multiply sequencer.
interface dsp_mul_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        flush;
   logic        busy;
   logic        result_valid;
   logic [31:0] result;

   modport master (
      output req_valid, req_op, req_a, req_b, flush,
      input  req_ready, busy, result_valid, result
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, flush,
      output req_ready, busy, result_valid, result
   );
endinterface

// File: rtl/dsp_mul_sequencer_mul16.sv
// Unsigned 16x16 multiplier with LATENCY register stages, standing in for the
// SB_MAC16 hard block in unsigned multiply mode with 32-bit output.
module dsp_mul16_pipe #(
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);

   logic [31:0] stage [LATENCY];

   always_ff @(posedge clk) begin
      stage[0] <= {16'b0, a} * {16'b0, b};
   end

   for (genvar g = 1; g < LATENCY; g++) begin : g_stage
      always_ff @(posedge clk) begin
         stage[g] <= stage[g-1];
      end
   end

   assign p = stage[LATENCY-1];

endmodule

// File: rtl/dsp_mul_sequencer.sv
// RV32M multiply unit: four 16x16 partials through one shared DSP multiplier,
// 64-bit accumulation, signed correction, then low/high word select.
module dsp_mul_sequencer
   import dsp_mul_sequencer_pkg::*;
#(
   parameter int unsigned DSP_LATENCY = 1
) (
   input logic               clk,
   input logic               rst,
   dsp_mul_sequencer_if.slave bus
);

   mul_state_e  state, state_next;
   logic        ready, busy, issue, accept;
   part_idx_t   part_cnt;
   logic [1:0]  drain_cnt;
   logic [31:0] a_q, b_q;
   mul_op_e     op_q;
   logic [63:0] acc, corrected;
   logic [15:0] mul_a, mul_b;
   logic [31:0] prod;
   logic        result_valid;
   logic [31:0] result;

   logic        tag_valid [DSP_LATENCY];
   part_idx_t   tag_part  [DSP_LATENCY];
   logic        tag_out_valid;
   part_idx_t   tag_out_part;

   assign accept = bus.req_valid && ready && !bus.flush;

   always_ff @(posedge clk) begin
      if (rst) state <= MS_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (bus.flush) begin
         state_next = MS_IDLE;
      end else begin
         case (state)
            MS_IDLE:  if (accept) state_next = MS_ISSUE;
            MS_ISSUE: if (part_cnt == PART_HH) state_next = MS_DRAIN;
            MS_DRAIN: if (drain_cnt == 2'(DSP_LATENCY - 1)) state_next = MS_FIX;
            MS_FIX:   state_next = MS_IDLE;
            default:  state_next = MS_IDLE;
         endcase
      end
   end

   always_comb begin
      ready = (state == MS_IDLE);
      busy  = (state != MS_IDLE);
      issue = (state == MS_ISSUE);
   end

   assign mul_a = part_cnt[1] ? a_q[31:16] : a_q[15:0];
   assign mul_b = part_cnt[0] ? b_q[31:16] : b_q[15:0];

   dsp_mul16_pipe #(.LATENCY(DSP_LATENCY)) u_mul16 (
      .clk (clk),
      .a   (mul_a),
      .b   (mul_b),
      .p   (prod)
   );

   // Tag pipe mirrors the multiplier's register depth so each product
   // arrives together with the shift it needs.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) tag_valid[0] <= 1'b0;
      else                  tag_valid[0] <= issue;
      tag_part[0] <= part_cnt;
   end

   for (genvar g = 1; g < DSP_LATENCY; g++) begin : g_tag
      always_ff @(posedge clk) begin
         if (rst || bus.flush) tag_valid[g] <= 1'b0;
         else                  tag_valid[g] <= tag_valid[g-1];
         tag_part[g] <= tag_part[g-1];
      end
   end

   assign tag_out_valid = tag_valid[DSP_LATENCY-1];
   assign tag_out_part  = tag_part[DSP_LATENCY-1];

   always_comb begin
      corrected = acc;
      if (a_is_signed(op_q) && a_q[31]) corrected = corrected - {b_q, 32'b0};
      if (b_is_signed(op_q) && b_q[31]) corrected = corrected - {a_q, 32'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc          <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= MUL_OP_MUL;
         part_cnt     <= PART_LL;
         drain_cnt    <= '0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (bus.flush) begin
            acc <= '0;
         end else if (accept) begin
            acc      <= '0;
            a_q      <= bus.req_a;
            b_q      <= bus.req_b;
            op_q     <= mul_op_e'(bus.req_op);
            part_cnt <= PART_LL;
         end else begin
            if (tag_out_valid)
               acc <= acc + ({32'b0, prod} << partial_shift(tag_out_part));
            if (state == MS_ISSUE) begin
               part_cnt  <= part_cnt + 2'd1;
               drain_cnt <= '0;
            end
            if (state == MS_DRAIN) drain_cnt <= drain_cnt + 2'd1;
            if (state == MS_FIX) begin
               result_valid <= 1'b1;
               result       <= (op_q == MUL_OP_MUL) ? corrected[31:0] : corrected[63:32];
            end
         end
      end
   end

   assign bus.req_ready    = ready;
   assign bus.busy         = busy;
   assign bus.result_valid = result_valid;
   assign bus.result       = result;

endmodule

// File: tb/tb_dsp_mul_sequencer.sv
// Self-checking bench: one sequencer per DSP latency (1..3), a shared driver
// steered by sel, and a scoreboard checking value and arrival cycle of each result.
module tb_dsp_mul_sequencer;
   import dsp_mul_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req_valid, flush;
   logic [1:0]  req_op;
   logic [31:0] req_a, req_b, req_exp;
   int          sel;

   dsp_mul_sequencer_if bus1 ();
   dsp_mul_sequencer_if bus2 ();
   dsp_mul_sequencer_if bus3 ();

   assign bus1.req_valid = req_valid && (sel == 0);
   assign bus2.req_valid = req_valid && (sel == 1);
   assign bus3.req_valid = req_valid && (sel == 2);
   assign bus1.req_op = req_op;  assign bus1.req_a = req_a;  assign bus1.req_b = req_b;  assign bus1.flush = flush;
   assign bus2.req_op = req_op;  assign bus2.req_a = req_a;  assign bus2.req_b = req_b;  assign bus2.flush = flush;
   assign bus3.req_op = req_op;  assign bus3.req_a = req_a;  assign bus3.req_b = req_b;  assign bus3.flush = flush;

   dsp_mul_sequencer #(.DSP_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   dsp_mul_sequencer #(.DSP_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
   dsp_mul_sequencer #(.DSP_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

   logic        m_ready, m_busy, m_rv;
   logic [31:0] m_result;
   always_comb begin
      case (sel)
         1:       begin m_ready = bus2.req_ready; m_busy = bus2.busy; m_rv = bus2.result_valid; m_result = bus2.result; end
         2:       begin m_ready = bus3.req_ready; m_busy = bus3.busy; m_rv = bus3.result_valid; m_result = bus3.result; end
         default: begin m_ready = bus1.req_ready; m_busy = bus1.busy; m_rv = bus1.result_valid; m_result = bus1.result; end
      endcase
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d, latency %0d)", name, act, exp, cyc, sel + 1);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] xa, xb, p;
      xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = xa * xb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   typedef struct {
      logic [31:0] value;
      int          due;
   } exp_t;
   exp_t sb[$];

   // Scoreboard: push on accept, pop on result_valid; flush/rst drop the in-flight entry.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
      end else begin
         check("ready_vs_busy", {63'b0, m_ready}, {63'b0, !m_busy});
         if (m_rv) begin
            if (sb.size() == 0) begin
               check("unexpected_result_valid", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               check("result", {32'b0, m_result}, {32'b0, e.value});
               check("result_cycle", 64'(cyc), 64'(e.due));
            end
         end
         if (flush && m_busy) sb.delete();
         if (req_valid && m_ready && !flush) sb.push_back('{req_exp, cyc + 6 + sel + 1});
      end
   end

   // Call at #1 after a posedge; returns at #1 after the posedge following accept.
   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      req_op = op; req_a = a; req_b = b; req_exp = exp; req_valid = 1'b1;
      for (int unsigned i = 0; i < 200; i++) begin
         @(negedge clk);
         if (m_ready && !flush) break;
         if (i == 199) check("accept_timeout", 64'd1, 64'd0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = $urandom;
      req_b = $urandom;
   endtask

   task automatic wait_idle();
      for (int unsigned i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !m_busy) break;
         if (i == 99) check("idle_timeout", 64'd1, 64'd0);
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;
   vec_t vt [8];

   int          busy_cnt;
   logic [31:0] old_result;
   logic [31:0] ra, rb;
   logic [1:0]  rop;

   initial begin
      vt[0] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vt[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
      vt[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vt[3] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vt[4] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
      vt[5] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
      vt[6] = '{2'b10, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
      vt[7] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};

      rst = 1'b1; req_valid = 1'b0; flush = 1'b0; sel = 0;
      req_op = 2'b00; req_a = '0; req_b = '0; req_exp = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         check("reset_ready", {63'b0, m_ready}, 64'd1);
         check("reset_busy", {63'b0, m_busy}, 64'd0);
         check("reset_result_valid", {63'b0, m_rv}, 64'd0);
         check("reset_result", {32'b0, m_result}, 64'd0);
      end
      sel = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // MUL 3x5 at latency 1: busy for six cycles, result seven after accept.
      send(2'b00, 32'd3, 32'd5, 32'h0000_000F);
      busy_cnt = 0;
      for (int unsigned i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m_rv) break;
         if (m_busy) busy_cnt++;
      end
      check("busy_cycles", 64'(busy_cnt), 64'd6);
      wait_idle();

      for (int unsigned i = 0; i < 8; i++) begin
         send(vt[i].op, vt[i].a, vt[i].b, vt[i].exp);
         wait_idle();
      end

      // Flush on the second ISSUE cycle.
      old_result = m_result;
      send(2'b00, 32'd9, 32'd9, 32'd81);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy", {63'b0, m_busy}, 64'd0);
      check("flush_ready", {63'b0, m_ready}, 64'd1);
      repeat (12) @(posedge clk);
      #1;
      check("flush_result_kept", {32'b0, m_result}, {32'b0, old_result});
      send(2'b00, 32'd7, 32'd6, 32'h0000_002A);
      wait_idle();

      // Back-to-back with req_valid held: second accept lands on first result_valid.
      req_op = 2'b00; req_a = 32'd2; req_b = 32'd2; req_exp = 32'd4; req_valid = 1'b1;
      for (int unsigned i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m_ready) break;
      end
      @(posedge clk); #1;
      req_a = 32'd4; req_b = 32'd4; req_exp = 32'd16;
      for (int unsigned i = 0; i < 50; i++) begin
         @(negedge clk);
         if (m_ready) break;
         if (i == 49) check("b2b_timeout", 64'd1, 64'd0);
      end
      check("b2b_accept_on_result", {63'b0, m_rv}, 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_idle();

      for (int s = 0; s < 3; s++) begin
         sel = s;
         @(posedge clk); #1;
         for (int unsigned i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 4 == 0) ra[31] = 1'b1;
            if (i % 3 == 0) rb[31] = 1'b1;
            send(rop, ra, rb, model(rop, ra, rb));
            wait_idle();
         end
      end

      // rst asserted in the first DRAIN cycle at latency 2.
      sel = 1;
      @(posedge clk); #1;
      send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_ready", {63'b0, m_ready}, 64'd1);
      check("rst_mid_busy", {63'b0, m_busy}, 64'd0);
      check("rst_mid_result_valid", {63'b0, m_rv}, 64'd0);
      check("rst_mid_result", {32'b0, m_result}, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      send(2'b00, 32'd3, 32'd3, 32'd9);
      wait_idle();
      repeat (5) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
